// File: rtl/x7_seg.sv
// rtl/x7_seg.sv - time-multiplexed hex driver for a 4-digit common-anode 7-segment display
module x7_seg #(
  parameter int CNT_W = 19
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] x,
  output logic [6:0] a_to_g,
  output logic [3:0] an
);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_sel;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic [6:0]       w_seg;

  // Free-running scan counter; wraps silently so the scan never stalls.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_sel = r_cnt[CNT_W-1 -: 2];

  // Pick the anode and nibble for the current digit; digits 2 and 3 stay dark.
  always_comb begin
    an      = 4'b1111;
    w_nib   = 4'h0;
    w_blank = 1'b1;
    case (w_sel)
      2'd0: begin
        an      = 4'b1110;
        w_nib   = x[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        an      = 4'b1101;
        w_nib   = x[7:4];
        w_blank = 1'b0;
      end
      default: begin
        an      = 4'b1111;
        w_nib   = 4'h0;
        w_blank = 1'b1;
      end
    endcase
  end

  // Hex-to-segment decode, bits a..g, active-low.
  always_comb begin
    w_seg = 7'b1111111;
    case (w_nib)
      4'h0:    w_seg = 7'b0000001;
      4'h1:    w_seg = 7'b1001111;
      4'h2:    w_seg = 7'b0010010;
      4'h3:    w_seg = 7'b0000110;
      4'h4:    w_seg = 7'b1001100;
      4'h5:    w_seg = 7'b0100100;
      4'h6:    w_seg = 7'b0100000;
      4'h7:    w_seg = 7'b0001111;
      4'h8:    w_seg = 7'b0000000;
      4'h9:    w_seg = 7'b0000100;
      4'hA:    w_seg = 7'b0001000;
      4'hB:    w_seg = 7'b1100000;
      4'hC:    w_seg = 7'b0110001;
      4'hD:    w_seg = 7'b1000010;
      4'hE:    w_seg = 7'b0110000;
      default: w_seg = 7'b0111000;
    endcase
  end

  assign a_to_g = w_blank ? 7'b1111111 : w_seg;

endmodule

// File: tb/tb_x7_seg.sv
// tb/tb_x7_seg.sv - self-checking bench for x7_seg with a 4-bit scan counter
module tb_x7_seg;

  localparam int CNT_W = 4;
  localparam int SCAN  = 1 << CNT_W;
  localparam int DWELL = 1 << (CNT_W - 2);

  logic       clk;
  logic       clr;
  logic [7:0] x;
  logic [6:0] a_to_g;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;

  logic [6:0] seg_tab [16];

  typedef struct {
    logic [7:0] x;
    logic [3:0] an;
    logic [6:0] seg;
  } vec_t;

  vec_t vecs [17];

  x7_seg #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .clr    (clr),
    .x      (x),
    .a_to_g (a_to_g),
    .an     (an)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; the model counter follows the clear/increment rule.
  task automatic tick();
    @(posedge clk);
    if (clr) mcnt = 0;
    else     mcnt = (mcnt + 1) % SCAN;
    #1;
  endtask

  function automatic int m_digit();
    return mcnt / DWELL;
  endfunction

  function automatic logic [3:0] m_an();
    int d = m_digit();
    if (d < 2) return ~(4'b0001 << d);
    return 4'b1111;
  endfunction

  function automatic logic [6:0] m_seg();
    int d = m_digit();
    if (d == 0) return seg_tab[x % 16];
    if (d == 1) return seg_tab[x / 16];
    return 7'b1111111;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_an"}, 32'(an), 32'(m_an()));
    chk({tag, "_seg"}, 32'(a_to_g), 32'(m_seg()));
  endtask

  initial begin
    int guard;

    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
    seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
    seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
    seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;

    for (int i = 0; i < 17; i++) begin
      vecs[i].x = 8'hAA;
      if (i < 4 || i == 16) begin
        vecs[i].an = 4'b1110; vecs[i].seg = 7'b0001000;
      end else if (i < 8) begin
        vecs[i].an = 4'b1101; vecs[i].seg = 7'b0001000;
      end else begin
        vecs[i].an = 4'b1111; vecs[i].seg = 7'b1111111;
      end
    end

    clr = 1'b1;
    x   = 8'h00;

    // Reset held for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_an", 32'(an), 32'h0000000E);
      chk("rst_seg", 32'(a_to_g), 32'(7'b0000001));
    end

    // Scan sequence with x = AA, starting on the cycle clr falls.
    clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) tick();
      x = vecs[i].x;
      #1;
      chk($sformatf("scan%0d_an", i), 32'(an), 32'(vecs[i].an));
      chk($sformatf("scan%0d_seg", i), 32'(a_to_g), 32'(vecs[i].seg));
    end

    // Distinct nibbles.
    x = 8'h3C;
    for (int i = 0; i < SCAN; i++) begin
      tick();
      chk_model("x3c");
      if (m_digit() == 0) chk("x3c_d0", 32'(a_to_g), 32'(7'b0110001));
      if (m_digit() == 1) chk("x3c_d1", 32'(a_to_g), 32'(7'b0000110));
    end

    // Full decode sweep on digit 0, several x changes inside one cycle.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int n = 0; n < 16; n++) begin
      x = 8'(n) | 8'h50;
      #1;
      chk($sformatf("sweep%0d_seg", n), 32'(a_to_g), 32'(seg_tab[n]));
      chk($sformatf("sweep%0d_an", n), 32'(an), 32'h0000000E);
    end

    // Mid-scan reset while digit 1 is selected.
    x = 8'h71;
    guard = 0;
    tick();
    while (m_digit() != 1 && guard < 32) begin
      tick();
      guard++;
    end
    chk("reach_d1", 32'(guard < 32), 32'd1);
    chk("pre_midrst_an", 32'(an), 32'h0000000D);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("midrst_an", 32'(an), 32'h0000000E);
    for (int i = 0; i <= DWELL; i++) begin
      if (i > 0) tick();
      chk($sformatf("midrst%0d_an", i), 32'(an), (i < DWELL) ? 32'h0000000E : 32'h0000000D);
    end

    // Random free-running run with occasional clears.
    for (int i = 0; i < 64; i++) begin
      x   = 8'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      #1;
      chk_model("rnd");
      chk("rnd_onehot", 32'($countones(~an) <= 1), 32'd1);
      chk("rnd_blank", 32'(an == 4'b1111), 32'(m_digit() >= 2));
      tick();
    end
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
